// File: rtl/sa_result_drain_pkg.sv
// Shared types and sizing helpers for the systolic-array result drain.
// Defaults mirror the standard 8x8, 8-bit array build.
package sa_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int HPE_DEF   = 8;
    localparam int VPE_DEF   = 8;

    // Index width for a count of n items; at least 1 so single-element axes stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RES_W = 2 * WIDTH_DEF;
    localparam int N_RES = HPE_DEF * VPE_DEF;
    localparam int ROW_W = idx_w(VPE_DEF);
    localparam int COL_W = idx_w(HPE_DEF);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/sa_result_drain_if.sv
// Result stream interface: one product per beat with row/col tags and a last flag.
interface sa_result_drain_if
    import sa_pkg::*;
#(
    parameter int RES_W_P = sa_pkg::RES_W,
    parameter int ROW_W_P = sa_pkg::ROW_W,
    parameter int COL_W_P = sa_pkg::COL_W
);
    logic [RES_W_P-1:0] OUT_DATA;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic [ROW_W_P-1:0] OUT_ROW;
    logic [COL_W_P-1:0] OUT_COL;
    logic               OUT_LAST;

    modport master (
        output OUT_DATA, OUT_VALID, OUT_ROW, OUT_COL, OUT_LAST,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA, OUT_VALID, OUT_ROW, OUT_COL, OUT_LAST,
        output OUT_READY
    );
endinterface

// File: rtl/sa_result_drain_idx.sv
// Row-major row/col/linear index counter with column wrap and last-element detect.
// Shared with the operand skew feeder.
module sa_drain_idx #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ROW_W = 3,
    parameter int COL_W = 3,
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ROWS * COLS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
            r_idx <= '0;
        end else if (i_adv) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == COL_MAX) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_idx  = r_idx;
    assign o_last = (r_idx == IDX_MAX);
endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the array result vector on CAP and streams it out row-major, one product per beat.
// Define SA_DRAIN_RELU_EN to clamp negative (signed) products to zero at the output mux.
module sa_result_drain
    import sa_pkg::*;
#(
    parameter int HPE   = 8,
    parameter int VPE   = 8,
    parameter int WIDTH = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CAP,
    input  logic [2*WIDTH*HPE*VPE-1:0]   YY1,
    sa_result_drain_if.master            out_if,
    output logic                         BUSY,
    output logic                         OVF
);
    localparam int RW   = 2 * WIDTH;
    localparam int NR   = HPE * VPE;
    localparam int IW   = idx_w(NR);
    localparam int RRW  = idx_w(VPE);
    localparam int CCW  = idx_w(HPE);

    localparam logic [0:0] S_IDLE  = 1'(IDLE);
    localparam logic [0:0] S_DRAIN = 1'(DRAIN);

    logic [0:0]          r_state;
    logic [RW*NR-1:0]    r_shadow;
    logic                r_ovf;

    logic                w_accept;
    logic                w_done;
    logic                w_cap_ok;
    logic                w_last;
    logic [IW-1:0]       w_idx;
    logic [RRW-1:0]      w_row;
    logic [CCW-1:0]      w_col;
    logic [RW-1:0]       w_elem;
    logic [RW-1:0]       w_out;

    assign w_accept = (r_state == S_DRAIN) && out_if.OUT_READY;
    assign w_done   = w_accept && w_last;
    // A capture is taken when idle, or when it coincides with the final accept (no bubble).
    assign w_cap_ok = CAP && ((r_state == S_IDLE) || w_done);

    sa_drain_idx #(
        .ROWS  (VPE),
        .COLS  (HPE),
        .ROW_W (RRW),
        .COL_W (CCW),
        .IDX_W (IW)
    ) u_idx (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_clr   (w_cap_ok || w_done),
        .i_adv   (w_accept && !w_last),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_idx   (w_idx),
        .o_last  (w_last)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_cap_ok) begin
                r_shadow <= YY1;
            end
            r_ovf <= CAP && (r_state == S_DRAIN) && !w_done;
            if (w_cap_ok) begin
                r_state <= S_DRAIN;
            end else if (w_done) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign w_elem = r_shadow[w_idx*RW +: RW];

`ifdef SA_DRAIN_RELU_EN
    assign w_out = w_elem[RW-1] ? '0 : w_elem;
`else
    assign w_out = w_elem;
`endif

    assign out_if.OUT_DATA  = w_out;
    assign out_if.OUT_VALID = (r_state == S_DRAIN);
    assign out_if.OUT_ROW   = w_row;
    assign out_if.OUT_COL   = w_col;
    assign out_if.OUT_LAST  = (r_state == S_DRAIN) && w_last;
    assign BUSY             = (r_state == S_DRAIN);
    assign OVF              = r_ovf;
endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain on a 2x2 array of 16-bit products.
module tb_sa_result_drain;
    localparam int HPE   = 2;
    localparam int VPE   = 2;
    localparam int WIDTH = 8;

    logic        CLK;
    logic        RST;
    logic        CAP;
    logic [63:0] YY1;
    logic        BUSY;
    logic        OVF;

    int errors;
    int checks;

    sa_result_drain_if #(.RES_W_P(16), .ROW_W_P(1), .COL_W_P(1)) s_if ();

    sa_result_drain #(.HPE(HPE), .VPE(VPE), .WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CAP    (CAP),
        .YY1    (YY1),
        .out_if (s_if.master),
        .BUSY   (BUSY),
        .OVF    (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] SNAP_A = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    localparam logic [63:0] SNAP_B = {16'h2003, 16'h2002, 16'h2001, 16'h2000};

    // Check one expected beat: data, tags, last and valid.
    task automatic check_beat(input string nm, input logic [15:0] d, input int k);
        checks++;
        if (s_if.OUT_VALID !== 1'b1 || s_if.OUT_DATA !== d ||
            s_if.OUT_ROW !== 1'(k / 2) || s_if.OUT_COL !== 1'(k % 2) ||
            s_if.OUT_LAST !== (k == 3)) begin
            errors++;
            $display("FAIL %s k=%0d: got v=%b d=%h r=%b c=%b l=%b, want v=1 d=%h r=%0d c=%0d l=%0d",
                     nm, k, s_if.OUT_VALID, s_if.OUT_DATA, s_if.OUT_ROW, s_if.OUT_COL,
                     s_if.OUT_LAST, d, k / 2, k % 2, (k == 3));
        end
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (s_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || s_if.OUT_LAST !== 1'b0) begin
            errors++;
            $display("FAIL %s: got v=%b busy=%b last=%b, want all 0",
                     nm, s_if.OUT_VALID, BUSY, s_if.OUT_LAST);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; CAP = 1'b0; YY1 = '0; s_if.OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (s_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0 || s_if.OUT_LAST !== 1'b0 ||
            s_if.OUT_DATA !== 16'h0 || s_if.OUT_ROW !== 1'b0 || s_if.OUT_COL !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b busy=%b ovf=%b last=%b d=%h r=%b c=%b, want all 0",
                     s_if.OUT_VALID, BUSY, OVF, s_if.OUT_LAST, s_if.OUT_DATA, s_if.OUT_ROW, s_if.OUT_COL);
        end
        RST = 1'b1;
        @(negedge CLK);
        check_idle("reset_release");
    endtask

    task automatic test_stream();
        logic [63:0] snap;
        snap = SNAP_A;
        s_if.OUT_READY = 1'b1;
        YY1 = snap; CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0; YY1 = '0;
        for (int k = 0; k < 4; k++) begin
            check_beat("stream", snap[k*16 +: 16], k);
            @(negedge CLK);
        end
        check_idle("stream_end");
    endtask

    task automatic test_backpressure();
        logic [63:0] snap;
        logic [15:0] pat;
        int          got;
        snap = SNAP_A;
        pat  = 16'b1101_1010_1101_1001; // LSB first: 1,0,0,1,1,0,1,1,...
        got  = 0;
        s_if.OUT_READY = 1'b0;
        YY1 = snap; CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0;
        for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
            s_if.OUT_READY = pat[cyc];
            check_beat("bp", snap[got*16 +: 16], got);
            if (pat[cyc]) got++;
            @(negedge CLK);
        end
        s_if.OUT_READY = 1'b1;
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d accepts, want 4", got);
        end
        check_idle("bp_end");
    endtask

    task automatic test_ovf();
        s_if.OUT_READY = 1'b1;
        YY1 = SNAP_A; CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0;
        check_beat("ovf", 16'h1000, 0);
        @(negedge CLK);
        check_beat("ovf", 16'h1001, 1);
        YY1 = SNAP_B; CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0;
        check_beat("ovf", 16'h1002, 2);
        checks++;
        if (OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pulse: got %b want 1", OVF);
        end
        @(negedge CLK);
        check_beat("ovf", 16'h1003, 3);
        checks++;
        if (OVF !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", OVF);
        end
        @(negedge CLK);
        check_idle("ovf_end");
    endtask

    task automatic test_back_to_back();
        s_if.OUT_READY = 1'b1;
        YY1 = SNAP_A; CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_beat("b2b_a", SNAP_A[k*16 +: 16], k);
            if (k == 3) begin
                YY1 = SNAP_B; CAP = 1'b1;
            end
            @(negedge CLK);
        end
        CAP = 1'b0;
        checks++;
        if (OVF !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ovf: got ovf=%b busy=%b want ovf=0 busy=1", OVF, BUSY);
        end
        for (int k = 0; k < 4; k++) begin
            check_beat("b2b_b", SNAP_B[k*16 +: 16], k);
            @(negedge CLK);
        end
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid();
        s_if.OUT_READY = 1'b1;
        YY1 = SNAP_A; CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0;
        check_beat("rmid", 16'h1000, 0);
        @(negedge CLK);
        check_beat("rmid", 16'h1001, 1);
        CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0;
        s_if.OUT_READY = 1'b0;
        check_beat("rmid", 16'h1002, 2);
        RST = 1'b0;
        #1;
        checks++;
        if (s_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL rmid_abort: got v=%b busy=%b ovf=%b want 0", s_if.OUT_VALID, BUSY, OVF);
        end
        @(negedge CLK);
        RST = 1'b1;
        s_if.OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (s_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet cyc=%0d: got v=%b busy=%b ovf=%b want 0",
                         i, s_if.OUT_VALID, BUSY, OVF);
            end
        end
    endtask

    task automatic test_relu();
        logic [63:0] snap;
        logic [63:0] expv;
        snap = {16'h7FFF, 16'h8000, 16'h0005, 16'hFFFF};
`ifdef SA_DRAIN_RELU_EN
        expv = {16'h7FFF, 16'h0000, 16'h0005, 16'h0000};
`else
        expv = snap;
`endif
        s_if.OUT_READY = 1'b1;
        YY1 = snap; CAP = 1'b1;
        @(negedge CLK);
        CAP = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_beat("relu", expv[k*16 +: 16], k);
            @(negedge CLK);
        end
        check_idle("relu_end");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
